// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// A grant latches the winning byte, pulses tx_start, tracks tx_busy and then inserts an idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic                         err_pulse,
    output logic [2:0]                   dbg_state_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [ID_W:0]    NUM_REQ_L = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam state_t POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [DATA_W-1:0]  lane [NUM_REQ];
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic [ID_W:0]      sum;
    logic               found;
    logic               timeout;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        winner = grant_id_q;
        found  = 1'b0;
        idx    = '0;
        sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, grant_id_q} + (ID_W + 1)'(k);
            if (sum >= NUM_REQ_L) begin
                sum = sum - NUM_REQ_L;
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOAD;
                    grant_id_d = winner;
                    tx_data_d  = lane[winner];
                end
            end
            LOAD: state_d = START;
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout   = 1'b1;
                    state_d   = POST_FRAME;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d   = POST_FRAME;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_id_q <= ID_LAST;
            tx_data_q  <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Pulses decode straight from registered state, so reset clears them immediately.
    always_comb begin
        ack = '0;
        if (state_q == LOAD) begin
            ack[grant_id_q] = 1'b1;
        end
    end

    assign tx_start    = (state_q == START);
    assign err_pulse   = timeout;
    assign grant_id    = grant_id_q;
    assign tx_data     = tx_data_q;
    assign dbg_state_o = state_q;

endmodule
